// File: rtl/xalu_scheduler.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, holds busy for a fixed latency, then commits.
// The 64-bit result is computed at acceptance and parked until the latency expires.
module xalu_scheduler #(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        xalu_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              d_uses_xalu,
  output logic              busy,
  output logic              done,
  output logic              stall_req,
  output logic              start_err,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                is_muldiv, is_div, is_sgn;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;
  logic                neg_a, neg_b, div_zero;
  logic [DATA_W-1:0]   mag_a, mag_b, mag_b_safe, uquo, urem, quo, rem;

  assign is_muldiv = ~xalu_op[2];
  assign is_div    = xalu_op[1];
  assign is_sgn    = ~xalu_op[0];

  // Low half of a 2W x 2W product of sign/zero-extended operands is the exact W x W product.
  assign ext_a = is_sgn ? {{DATA_W{src_a[DATA_W-1]}}, src_a} : {{DATA_W{1'b0}}, src_a};
  assign ext_b = is_sgn ? {{DATA_W{src_b[DATA_W-1]}}, src_b} : {{DATA_W{1'b0}}, src_b};
  assign prod  = ext_a * ext_b;

  // Signed division runs on magnitudes; MIN/-1 falls out as quotient MIN, remainder 0.
  assign neg_a      = is_sgn & src_a[DATA_W-1];
  assign neg_b      = is_sgn & src_b[DATA_W-1];
  assign mag_a      = neg_a ? (~src_a + 1'b1) : src_a;
  assign mag_b      = neg_b ? (~src_b + 1'b1) : src_b;
  assign div_zero   = (src_b == '0);
  assign mag_b_safe = div_zero ? {{(DATA_W-1){1'b0}}, 1'b1} : mag_b;
  assign uquo       = mag_a / mag_b_safe;
  assign urem       = mag_a % mag_b_safe;
  assign quo        = (neg_a ^ neg_b) ? (~uquo + 1'b1) : uquo;
  assign rem        = neg_a ? (~urem + 1'b1) : urem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_muldiv) begin
            state_d = ST_RUN;
            cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            res_d   = is_div ? {rem, quo} : prod;
            wr_d    = ~(is_div & div_zero);
          end else if (xalu_op[1:0] == 2'b00) begin
            hi_d = src_a;
          end else if (xalu_op[1:0] == 2'b01) begin
            lo_d = src_a;
          end
        end
      end
      ST_RUN: begin
        if (start) begin
          err_d = 1'b1;
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (wr_q) begin
            hi_d = res_q[2*DATA_W-1:DATA_W];
            lo_d = res_q[DATA_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign start_err = err_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = d_uses_xalu & (busy | (start & is_muldiv));

endmodule

// File: tb/tb_xalu_scheduler.sv
// Scoreboard bench for xalu_scheduler: directed scenarios followed by random traffic.
module tb_xalu_scheduler;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  xalu_op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        d_uses_xalu = 1'b0;
  logic        busy, done, stall_req, start_err;
  logic [31:0] hi, lo;

  xalu_scheduler #(.DATA_W(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .xalu_op(xalu_op),
    .src_a(src_a), .src_b(src_b), .d_uses_xalu(d_uses_xalu),
    .busy(busy), .done(done), .stall_req(stall_req), .start_err(start_err),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        scb[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          issue_c = -100;
  int          busy_until = -100;
  int          err_from = 1 << 30;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic on 64-bit integers; returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ohi,
                                             input logic [31:0] olo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = {ohi, olo};
    case (op)
      3'd0: res = sa * sb;
      3'd1: res = ua * ub;
      3'd2: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd3: if (b != 0) begin
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        res = {r[31:0], q[31:0]};
      end
      default: res = {ohi, olo};
    endcase
    return res;
  endfunction

  task automatic model_reset();
    scb.delete();
    issue_c    = -100;
    busy_until = -100;
    err_from   = 1 << 30;
    m_hi       = '0;
    m_lo       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start for a single cycle and record what the unit must do with it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int          n;
    start   = 1'b1;
    xalu_op = op;
    src_a   = a;
    src_b   = b;
    if (cyc <= busy_until) begin
      if (err_from > cyc + 1) err_from = cyc + 1;
    end else if (op < 3'd4) begin
      n          = (op < 3'd2) ? MC : DC;
      r          = ref_result(op, a, b, m_hi, m_lo);
      issue_c    = cyc;
      busy_until = cyc + n;
      scb.push_back('{cyc + n + 1, r[63:32], r[31:0]});
      m_hi = r[63:32];
      m_lo = r[31:0];
    end else if (op == 3'd4) begin
      m_hi = a;
    end else if (op == 3'd5) begin
      m_lo = a;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc <= busy_until + 1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", 64'(n), 64'(0));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every cycle, compare flags and pop the scoreboard on each done pulse.
  always @(negedge clk) begin
    logic busy_e, done_e;
    exp_t e;
    busy_e = (cyc > issue_c) && (cyc <= busy_until);
    chk("busy", 64'(busy), 64'(busy_e));
    chk("stall_req", 64'(stall_req), 64'(d_uses_xalu & (busy_e | (start & ~xalu_op[2]))));
    chk("start_err", 64'(start_err), 64'(cyc >= err_from));
    done_e = (scb.size() > 0) && (scb[0].cyc == cyc);
    chk("done", 64'(done), 64'(done_e));
    if (done_e) begin
      e = scb.pop_front();
      chk("hi_at_done", 64'(hi), 64'(e.hi));
      chk("lo_at_done", 64'(lo), 64'(e.lo));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    tick();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    reset = 1'b1;
    tick();

    // MULT / MULTU of 0xFFFFFFFF * 2 with busy length and done pulse
    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    chk("mult_busy_len", 64'(n), 64'(MC));
    chk("mult_done_pulse", 64'(done), 64'(1));
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFFE);
    tick();
    chk("mult_done_clear", 64'(done), 64'(0));
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    chk("multu_hi", 64'(hi), 64'h1);
    chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    // DIV -7/2, then divide by zero leaves HI/LO alone
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    chk("div_busy_len", 64'(n), 64'(DC));
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    issue(3'd2, 32'd5, 32'd0);
    wait_idle();
    chk("div0_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div0_hi", 64'(hi), 64'hFFFF_FFFF);

    // DIVU 100/7 with MTLO attempted during busy cycle 3
    issue(3'd3, 32'd100, 32'd7);
    tick();
    tick();
    issue(3'd5, 32'h1234, 32'd0);
    chk("err_set", 64'(start_err), 64'(1));
    wait_idle();
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);

    // Reset mid-run clears everything
    issue(3'd0, 32'd3, 32'd3);
    tick();
    apply_reset();
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(start_err), 64'(0));

    // Stall window and back-to-back start in the done cycle
    d_uses_xalu = 1'b1;
    issue(3'd0, 32'd6, 32'd7);
    n = 0;
    while (stall_req && n < 50) begin
      n++;
      tick();
    end
    chk("stall_len_after_start", 64'(n), 64'(MC));
    chk("stall_in_done", 64'(stall_req), 64'(0));
    chk("done_b2b", 64'(done), 64'(1));
    issue(3'd1, 32'd9, 32'd11);
    chk("b2b_busy", 64'(busy), 64'(1));
    d_uses_xalu = 1'b0;
    wait_idle();
    chk("b2b_lo", 64'(lo), 64'd99);

    // MTHI/MTLO then reset at DIV busy cycle 4
    issue(3'd4, 32'hCAFE, 32'd0);
    issue(3'd5, 32'hBEEF, 32'd0);
    chk("mthi", 64'(hi), 64'hCAFE);
    chk("mtlo", 64'(lo), 64'hBEEF);
    issue(3'd2, 32'd50, 32'd3);
    tick();
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_div_busy", 64'(busy), 64'(0));
    chk("rst_div_hi", 64'(hi), 64'(0));
    chk("rst_div_lo", 64'(lo), 64'(0));
    tick();
    reset = 1'b1;
    repeat (DC + 2) tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) apply_reset();
      d_uses_xalu = 1'($urandom_range(0, 1));
      issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
      repeat ($urandom_range(0, 12)) tick();
    end
    wait_idle();
    chk("final_hi", 64'(hi), 64'(m_hi));
    chk("final_lo", 64'(lo), 64'(m_lo));
    chk("scoreboard_drained", 64'(scb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
